iddmm_a_update: RTL

- Word-serial accumulator stage of the IDDMM Montgomery datapath, directly downstream of the q-update stage.
- Per outer iteration i, consumes q_i from the q-update stage together with x_i, and streams y_j/m_j words from external RAMs.
- Computes A <- (A + x_i*Y + q_i*M) / 2^K one K-bit word per cycle, with a carry chain.
- Holds A in an internal (N+1)-word array and exports every written word on the wr_a_* bus that the q-update stage consumes.

---
 rtl/iddmm_pkg.sv | 20 ++
 rtl/iddmm_a_mac.sv | 53 +++++
 rtl/iddmm_a_update.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM Montgomery datapath.
// Word/double-word types default to the production word size.
package iddmm_pkg;

    localparam int KW = 128;
    localparam int NW = 32;
    localparam int PIPE_LAT = 3;

    typedef logic [KW-1:0]   word_t;
    typedef logic [2*KW+1:0] dword_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINAL,
        DONE
    } state_t;

endpackage

// File: rtl/iddmm_a_mac.sv
// Two-stage multiply-accumulate: registered K x K products,
// then the 2K+2-bit sum with carry feedback.
module iddmm_a_mac #(
    parameter int K = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_vld,
    input  logic         zero,
    input  logic [K-1:0] x,
    input  logic [K-1:0] q,
    input  logic [K-1:0] y,
    input  logic [K-1:0] m,
    input  logic [K-1:0] a,
    output logic         out_vld,
    output logic [K-1:0] lo,
    output logic [K-1:0] carry_word
);

    logic [2*K-1:0] p_r;
    logic [2*K-1:0] r_r;
    logic [K-1:0]   a_r;
    logic [K+1:0]   carry;
    logic [2*K+1:0] t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            p_r     <= '0;
            r_r     <= '0;
            a_r     <= '0;
            carry   <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                p_r <= zero ? '0 : (2*K)'(x) * (2*K)'(y);
                r_r <= zero ? '0 : (2*K)'(q) * (2*K)'(m);
                a_r <= a;
            end
            if (clr)
                carry <= '0;
            else if (out_vld)
                carry <= t[2*K+1:K];
        end
    end

    assign t = (2*K+2)'(a_r) + (2*K+2)'(p_r)
             + (2*K+2)'(r_r) + (2*K+2)'(carry);
    assign lo = t[K-1:0];
    assign carry_word = carry[K-1:0];

endmodule

// File: rtl/iddmm_a_update.sv
// IDDMM A-update stage: A <- (A + x_i*Y + q*M) / 2^K,
// one word per cycle, every written A word exported on wr_a_*.
module iddmm_a_update
    import iddmm_pkg::*;
#(
    parameter int K      = KW,
    parameter int N      = NW,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              first,
    input  logic [K-1:0]      x_i,
    input  logic [K-1:0]      q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [K-1:0]      y_word,
    input  logic [K-1:0]      m_word,
    output logic              busy,
    output logic              wr_a_en,
    output logic [ADDR_W:0]   wr_a_addr,
    output logic [K-1:0]      wr_a_data,
    output logic              done
);

    localparam logic [ADDR_W:0] J_LAST = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] D_LAST = (ADDR_W+1)'(PIPE_LAT-1);

    state_t state, nstate;

    logic [ADDR_W:0] j;
    logic [K-1:0]    x_r, q_r;
    logic            first_r;
    logic            accept;

    logic            s0_vld, s0_zero;
    logic [K-1:0]    s0_a;
    logic [ADDR_W:0] s0_j, s1_j;

    logic            mac_vld;
    logic [K-1:0]    mac_lo, mac_carry;

    logic            we;
    logic [ADDR_W:0] waddr;
    logic [K-1:0]    wdata;

    logic [K-1:0] a_mem [N+1];

    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (start) nstate = ISSUE;
            ISSUE: if (j == J_LAST) nstate = DRAIN;
            DRAIN: if (j == D_LAST) nstate = FINAL;
            FINAL: nstate = DONE;
            DONE:  nstate = start ? ISSUE : IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Interior words come from the MAC; A[N] is the leftover carry.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (mac_vld && s1_j != '0) begin
            we    = 1'b1;
            waddr = s1_j - (ADDR_W+1)'(1);
            wdata = mac_lo;
        end else if (state == DRAIN && j == D_LAST) begin
            we    = 1'b1;
            waddr = J_LAST;
            wdata = mac_carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            x_r       <= '0;
            q_r       <= '0;
            first_r   <= 1'b0;
            s0_vld    <= 1'b0;
            s0_zero   <= 1'b0;
            s0_a      <= '0;
            s0_j      <= '0;
            s1_j      <= '0;
            wr_a_en   <= 1'b0;
            wr_a_addr <= '0;
            wr_a_data <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                x_r     <= x_i;
                q_r     <= q;
                first_r <= first;
                j       <= '0;
            end else if (state == ISSUE) begin
                j <= (j == J_LAST) ? '0 : j + (ADDR_W+1)'(1);
            end else if (state == DRAIN) begin
                j <= j + (ADDR_W+1)'(1);
            end
            s0_vld  <= (state == ISSUE);
            s0_zero <= (j == J_LAST);
            s0_a    <= first_r ? '0 : a_mem[j];
            s0_j    <= j;
            s1_j    <= s0_j;
            wr_a_en <= we;
            if (we) begin
                wr_a_addr <= waddr;
                wr_a_data <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            a_mem[waddr] <= wdata;
    end

    iddmm_a_mac #(.K(K)) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .in_vld     (s0_vld),
        .zero       (s0_zero),
        .x          (x_r),
        .q          (q_r),
        .y          (y_word),
        .m          (m_word),
        .a          (s0_a),
        .out_vld    (mac_vld),
        .lo         (mac_lo),
        .carry_word (mac_carry)
    );

    assign busy    = (state == ISSUE) || (state == DRAIN) || (state == FINAL);
    assign done    = (state == DONE);
    assign rd_en   = (state == ISSUE) && (j != J_LAST);
    assign rd_addr = rd_en ? j[ADDR_W-1:0] : '0;

endmodule
